// File: rtl/svc_rv_pkg.sv
// -----------------------------------------------------------------------------
// svc_rv_pkg
// Shared definitions for the regfile writeback path.
//   REG_ADDR_W : architectural register index width (x0..x31)
//   XLEN       : default register data width
//   wb_req_t   : one writeback request {addr, data}
// -----------------------------------------------------------------------------
package svc_rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/svc_rv_rf_wr_arb.sv
// -----------------------------------------------------------------------------
// svc_rv_rf_wr_arb
// Arbitrates the single regfile write port between two writeback sources.
// Source 0 (pipeline WB) has fixed priority. Source 1 (long-latency unit) is
// force-granted once it has lost MAX_WAIT consecutive cycles. The write port
// is registered; writes to x0 are accepted but never enable the port.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   s0_valid/s0_ready              pipeline WB handshake
//   s0_rd_addr/s0_rd_data          pipeline WB payload
//   s1_valid/s1_ready              long-latency unit handshake
//   s1_rd_addr/s1_rd_data          long-latency unit payload
//   rd_en/rd_addr/rd_data          registered regfile write port
//   s1_forced                      registered, high the cycle after a grant
//                                  to source 1 that blocked source 0
//
// The data field of wb_req_t is sized by svc_rv_pkg::XLEN, so XLEN here is
// expected to match the package value.
// -----------------------------------------------------------------------------
module svc_rv_rf_wr_arb
    import svc_rv_pkg::*;
#(
    parameter int XLEN     = svc_rv_pkg::XLEN,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [REG_ADDR_W-1:0] s0_rd_addr,
    input  logic [XLEN-1:0]       s0_rd_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [REG_ADDR_W-1:0] s1_rd_addr,
    input  logic [XLEN-1:0]       s1_rd_data,
    output logic                  rd_en,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_data,
    output logic                  s1_forced
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             force_gnt;
    logic             gnt0;
    logic             gnt1;
    wb_req_t          sel;

    always_comb begin
        force_gnt    = 1'b0;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        sel          = '0;
        wait_cnt_nxt = '0;

        force_gnt = s1_valid && (wait_cnt == CNT_MAX);
        gnt1      = s1_valid && (!s0_valid || force_gnt);
        gnt0      = s0_valid && !gnt1;

        if (gnt1) begin
            sel.addr = s1_rd_addr;
            sel.data = s1_rd_data;
        end else begin
            sel.addr = s0_rd_addr;
            sel.data = s0_rd_data;
        end

        // Counts consecutive losses only; any gap in s1_valid restarts it.
        if (s1_valid && !gnt1) begin
            wait_cnt_nxt = (wait_cnt == CNT_MAX) ? CNT_MAX : wait_cnt + 1'b1;
        end
    end

    assign s0_ready = gnt0;
    assign s1_ready = gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
            s1_forced <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            // x0 writes update address/data but keep the port disabled.
            rd_en     <= (gnt0 || gnt1) && (sel.addr != '0);
            s1_forced <= gnt1 && s0_valid;
            wait_cnt  <= wait_cnt_nxt;
            if (gnt0 || gnt1) begin
                rd_addr <= sel.addr;
                rd_data <= sel.data;
            end
        end
    end

endmodule
